// File: rtl/vs_rate_monitor.sv
// Multi-channel vsync rate monitor: counts selected edges per channel over a fixed
// window of post_clk cycles and publishes saturating counts with overflow/no-signal flags.
module vs_rate_monitor #(
  parameter int unsigned CH_NUM      = 2,
  parameter int unsigned WIN_CYCLES  = 65_000_000,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0,
  localparam int unsigned WIN_W      = $clog2(WIN_CYCLES)
) (
  input  logic                    post_clk,
  input  logic                    sys_rst,
  input  logic [CH_NUM-1:0]       i_vs,
  input  logic                    i_clr,
  output logic [CH_NUM*CNT_W-1:0] o_fps,
  output logic                    o_fps_vld,
  output logic [CH_NUM-1:0]       o_ovf,
  output logic [CH_NUM-1:0]       o_lost,
  output logic [WIN_W-1:0]        o_win_cnt
);

  localparam int unsigned WARM_END = SYNC_STAGES + 1;
  localparam int unsigned WARM_W   = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0][CH_NUM-1:0] sync_q;
  logic [CH_NUM-1:0]                  sync_out;
  logic [CH_NUM-1:0]                  prev_q;
  logic [WARM_W-1:0]                  warm_q;
  logic                               warm_done;
  logic [CH_NUM-1:0]                  edge_c;

  logic [CH_NUM-1:0][CNT_W-1:0] run_q;
  logic [CH_NUM-1:0][CNT_W-1:0] run_nxt;
  logic [CH_NUM-1:0]            ovf_q;
  logic [CH_NUM-1:0]            ovf_nxt;
  logic [CH_NUM-1:0]            lost_nxt;
  logic [CH_NUM*CNT_W-1:0]      fps_nxt;
  logic                         close_c;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WARM_W'(WARM_END));
  assign close_c   = (o_win_cnt == WIN_W'(WIN_CYCLES - 1));

  // Input synchroniser, previous-level register and post-reset warm-up counter
  always_ff @(posedge post_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync_q <= '0;
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_vs};
      prev_q <= sync_out;
      if (!warm_done) warm_q <= warm_q + WARM_W'(1);
    end
  end

  // Edge detect; masked until the pipeline holds real input samples
  always_comb begin
    edge_c = '0;
    if (warm_done) begin
      edge_c = (EDGE_MODE != 0) ? (sync_out & ~prev_q) : (~sync_out & prev_q);
    end
  end

  // Saturating per-channel increment; the result doubles as the published value at close
  always_comb begin
    run_nxt  = run_q;
    ovf_nxt  = ovf_q;
    lost_nxt = '0;
    fps_nxt  = '0;
    for (int n = 0; n < int'(CH_NUM); n++) begin
      if (edge_c[n]) begin
        if (&run_q[n]) ovf_nxt[n] = 1'b1;
        else           run_nxt[n] = run_q[n] + CNT_W'(1);
      end
      lost_nxt[n]                 = (run_nxt[n] == '0);
      fps_nxt[n*CNT_W +: CNT_W]   = run_nxt[n];
    end
  end

  // Window counter, running counts and published results; clear beats close
  always_ff @(posedge post_clk or posedge sys_rst) begin
    if (sys_rst) begin
      o_win_cnt <= '0;
      run_q     <= '0;
      ovf_q     <= '0;
      o_fps     <= '0;
      o_ovf     <= '0;
      o_lost    <= '0;
      o_fps_vld <= 1'b0;
    end else begin
      o_fps_vld <= 1'b0;
      if (i_clr) begin
        o_win_cnt <= '0;
        run_q     <= '0;
        ovf_q     <= '0;
      end else if (close_c) begin
        o_win_cnt <= '0;
        run_q     <= '0;
        ovf_q     <= '0;
        o_fps     <= fps_nxt;
        o_ovf     <= ovf_nxt;
        o_lost    <= lost_nxt;
        o_fps_vld <= 1'b1;
      end else begin
        o_win_cnt <= o_win_cnt + WIN_W'(1);
        run_q     <= run_nxt;
        ovf_q     <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vs_rate_monitor.sv
// Scoreboard bench for vs_rate_monitor: falling- and rising-edge instances share stimulus,
// a transition-history model predicts each window's report.
module tb_vs_rate_monitor;

  localparam int unsigned WIN   = 100;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CH    = 2;
  localparam int unsigned WIN_W = $clog2(WIN);
  localparam int          MAXC  = 15;
  localparam int          LAT   = 3;

  logic post_clk = 1'b0;
  logic sys_rst  = 1'b1;
  logic [CH-1:0] i_vs = '0;
  logic i_clr = 1'b0;

  logic [CH*CNT_W-1:0] fps_f, fps_r;
  logic                vld_f, vld_r;
  logic [CH-1:0]       ovf_f, ovf_r, lost_f, lost_r;
  logic [WIN_W-1:0]    win_f, win_r;

  vs_rate_monitor #(.CH_NUM(CH), .WIN_CYCLES(WIN), .CNT_W(CNT_W), .SYNC_STAGES(2), .EDGE_MODE(0)) u_fall (
    .post_clk(post_clk), .sys_rst(sys_rst), .i_vs(i_vs), .i_clr(i_clr),
    .o_fps(fps_f), .o_fps_vld(vld_f), .o_ovf(ovf_f), .o_lost(lost_f), .o_win_cnt(win_f));

  vs_rate_monitor #(.CH_NUM(CH), .WIN_CYCLES(WIN), .CNT_W(CNT_W), .SYNC_STAGES(2), .EDGE_MODE(1)) u_rise (
    .post_clk(post_clk), .sys_rst(sys_rst), .i_vs(i_vs), .i_clr(i_clr),
    .o_fps(fps_r), .o_fps_vld(vld_r), .o_ovf(ovf_r), .o_lost(lost_r), .o_win_cnt(win_r));

  always #5 post_clk = ~post_clk;

  typedef struct packed {
    logic [7:0]  fps;
    logic [1:0]  ovf;
    logic [1:0]  lost;
    logic [31:0] cyc;
  } exp_t;

  exp_t q_f[$];
  exp_t q_r[$];
  exp_t e_f, e_r;

  logic [1:0] hist[$];
  int cnt_f[2];
  int cnt_r[2];
  int wpos;
  int cur_t;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", nm, act, exp, cur_t);
    end
  endtask

  function automatic int sat(input int c);
    return (c > MAXC) ? MAXC : c;
  endfunction

  function automatic exp_t mk(input int c0, input int c1, input int cyc);
    exp_t r;
    r.fps  = {4'(sat(c1)), 4'(sat(c0))};
    r.ovf  = {1'(c1 > MAXC), 1'(c0 > MAXC)};
    r.lost = {1'(c1 == 0), 1'(c0 == 0)};
    r.cyc  = 32'(cyc);
    return r;
  endfunction

  // One post-release cycle: check window position, drive inputs, advance the model
  task automatic cyc(input logic [1:0] v, input logic clr);
    int ef[2];
    int er[2];
    int c;
    logic [1:0] a, b;
    chk("win_cnt_fall", int'(win_f), wpos);
    chk("win_cnt_rise", int'(win_r), wpos);
    i_vs  = v;
    i_clr = clr;
    hist.push_back(v);
    c = cur_t;
    for (int ch = 0; ch < 2; ch++) begin
      ef[ch] = 0;
      er[ch] = 0;
    end
    // A level change between cycles c-LAT and c-LAT+1 lands in the count during cycle c
    if (c >= LAT) begin
      a = hist[c-LAT];
      b = hist[c-LAT+1];
      for (int ch = 0; ch < 2; ch++) begin
        ef[ch] = (a[ch] && !b[ch]) ? 1 : 0;
        er[ch] = (!a[ch] && b[ch]) ? 1 : 0;
      end
    end
    if (clr) begin
      cnt_f = '{0, 0};
      cnt_r = '{0, 0};
      wpos  = 0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        cnt_f[ch] += ef[ch];
        cnt_r[ch] += er[ch];
      end
      if (wpos == int'(WIN) - 1) begin
        q_f.push_back(mk(cnt_f[0], cnt_f[1], c + 1));
        q_r.push_back(mk(cnt_r[0], cnt_r[1], c + 1));
        cnt_f = '{0, 0};
        cnt_r = '{0, 0};
        wpos  = 0;
      end else begin
        wpos++;
      end
    end
    cur_t++;
    @(negedge post_clk);
  endtask

  task automatic do_reset(input logic [1:0] v);
    sys_rst = 1'b1;
    i_vs    = v;
    i_clr   = 1'b0;
    #1;
    chk("rst_fps_fall",   int'(fps_f), 0);
    chk("rst_flags_fall", int'({vld_f, ovf_f, lost_f}), 0);
    chk("rst_win_fall",   int'(win_f), 0);
    chk("rst_fps_rise",   int'(fps_r), 0);
    chk("rst_flags_rise", int'({vld_r, ovf_r, lost_r}), 0);
    chk("rst_win_rise",   int'(win_r), 0);
    q_f.delete();
    q_r.delete();
    hist.delete();
    cnt_f = '{0, 0};
    cnt_r = '{0, 0};
    wpos  = 0;
    cur_t = 0;
    repeat (3) @(negedge post_clk);
    sys_rst = 1'b0;
  endtask

  // Scoreboard monitors: pop on every valid pulse, flag pulses that never arrive
  always @(posedge post_clk) begin
    #1;
    if (!sys_rst) begin
      if (vld_f) begin
        if (q_f.size() == 0) begin
          chk("unexpected_vld_fall", 1, 0);
        end else begin
          e_f = q_f.pop_front();
          chk("vld_time_fall", cur_t, int'(e_f.cyc));
          chk("fps_fall",  int'(fps_f),  int'(e_f.fps));
          chk("ovf_fall",  int'(ovf_f),  int'(e_f.ovf));
          chk("lost_fall", int'(lost_f), int'(e_f.lost));
        end
      end else if (q_f.size() > 0 && int'(q_f[0].cyc) <= cur_t) begin
        e_f = q_f.pop_front();
        chk("missing_vld_fall", 0, 1);
      end
    end
  end

  always @(posedge post_clk) begin
    #1;
    if (!sys_rst) begin
      if (vld_r) begin
        if (q_r.size() == 0) begin
          chk("unexpected_vld_rise", 1, 0);
        end else begin
          e_r = q_r.pop_front();
          chk("vld_time_rise", cur_t, int'(e_r.cyc));
          chk("fps_rise",  int'(fps_r),  int'(e_r.fps));
          chk("ovf_rise",  int'(ovf_r),  int'(e_r.ovf));
          chk("lost_rise", int'(lost_r), int'(e_r.lost));
        end
      end else if (q_r.size() > 0 && int'(q_r[0].cyc) <= cur_t) begin
        e_r = q_r.pop_front();
        chk("missing_vld_rise", 0, 1);
      end
    end
  end

  initial begin
    logic [1:0] v;
    int p;
    repeat (2) @(negedge post_clk);

    // 7 pulses on ch0, 3 on ch1 in the first window
    do_reset(2'b00);
    for (int t = 0; t < int'(WIN); t++)
      cyc({1'(t < 7 && t % 2 == 1), 1'(t < 15 && t % 2 == 1)}, 1'b0);

    // ch1 static high, ch0 random
    for (int t = 0; t < int'(WIN); t++)
      cyc({1'b1, 1'($urandom_range(0, 1))}, 1'b0);

    // ch0 toggles every cycle (saturates), then settles low
    for (int t = 0; t < int'(WIN); t++)
      cyc({1'b0, 1'(t < 90 && t % 2 == 1)}, 1'b0);
    // exactly two falling edges in the next window
    for (int t = 0; t < int'(WIN); t++)
      cyc({1'b0, 1'(t == 10 || t == 20)}, 1'b0);

    // five early edges plus one detected on the close cycle
    for (int t = 0; t < int'(WIN); t++)
      cyc({1'b0, 1'((t < 10 && t % 2 == 1) || t == 96)}, 1'b0);
    for (int t = 0; t < int'(WIN); t++)
      cyc({1'($urandom_range(0, 1)), 1'(t % 4 == 1)}, 1'b0);

    // soft clear at position 50 after four edges
    for (int t = 0; t <= 50; t++)
      cyc({1'b0, 1'(t < 8 && t % 2 == 1)}, 1'(t == 50));
    for (int t = 0; t < int'(WIN); t++)
      cyc({1'(t % 10 == 3), 1'(t > 20 && t < 26 && t % 2 == 1)}, 1'b0);

    // static high through a mid-window reset
    for (int t = 0; t < 40; t++)
      cyc(2'b11, 1'b0);
    chk("pre_reset_wpos", int'(win_f), 40);
    do_reset(2'b11);
    for (int t = 0; t < int'(WIN); t++)
      cyc(2'b11, 1'b0);

    // random windows with varying toggle density and rare clears
    v = 2'b11;
    for (int w = 0; w < 8; w++) begin
      p = (w % 4 == 0) ? 0 : int'($urandom_range(5, 60));
      for (int t = 0; t < int'(WIN); t++) begin
        for (int ch = 0; ch < 2; ch++)
          if (int'($urandom_range(0, 99)) < p) v[ch] = ~v[ch];
        cyc(v, 1'($urandom_range(0, 249) == 0));
      end
    end
    for (int t = 0; t < 4; t++)
      cyc(v, 1'b0);

    chk("pending_fall", q_f.size(), 0);
    chk("pending_rise", q_r.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
